bus_arbiter: RTL and testbench

- Two-master arbiter in front of the sys_bus CPU-side master port.
- M0 is the CPU load/store port; M1 is a secondary master (DMA / UART boot loader).
- Grants one master at a time and holds the grant until the slave completes the transfer (s_valid && s_ready).
- Fair round-robin between masters; back-to-back transfers to one master at one transfer per cycle.

---
 rtl/bus_arb_pkg.sv | 17 +
 rtl/rr_pick2.sv | 20 ++
 rtl/bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_bus_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared encodings for the two-master sys_bus arbiter: FSM states, grant_id codes
// and the read word returned on a forced timeout abort.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    localparam logic [1:0]  GRANT_NONE   = 2'b00;
    localparam logic [1:0]  GRANT_M0     = 2'b01;
    localparam logic [1:0]  GRANT_M1     = 2'b10;

    localparam logic [31:0] BUS_ERR_WORD = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_pick2.sv
// Two-input round-robin picker: a lone requester wins, and on a tie the requester
// that was not granted last wins. Output is one-hot, or zero when nobody asks.
module rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_pick
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        o_pick = 2'b00;
        case (i_req)
            2'b01:   o_pick = 2'b01;
            2'b10:   o_pick = 2'b10;
            2'b11:   o_pick = i_last ? 2'b01 : 2'b10;
            default: o_pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter between the CPU port (M0) and a secondary master (M1) in front
// of sys_bus. Define BUS_TIMEOUT_EN to abort transfers stalled for TIMEOUT_CYCLES.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] m0_addr,
    input  logic        m0_valid,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wmask,
    input  logic        m0_wen,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,

    input  logic [31:0] m1_addr,
    input  logic        m1_valid,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wmask,
    input  logic        m1_wen,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,

    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wmask,
    output logic        s_wen,
    output logic        s_valid,
    input  logic [31:0] s_rdata,
    input  logic        s_ready,

    output logic [1:0]  grant_id,
    output logic        bus_err
);

    state_e      r_state;
    state_e      w_state_nxt;
    logic        r_last_grant;   // 0 = M0 was served last, 1 = M1
    logic        w_in_gnt;
    logic        w_sel;
    logic        w_mx_valid;
    logic        w_done;
    logic        w_tmo;
    logic        w_pick_last;
    logic [1:0]  w_pick;
    logic        w_ready;
    logic [31:0] w_rdata;

    assign w_in_gnt   = (r_state == GNT0) || (r_state == GNT1);
    assign w_sel      = (r_state == GNT1);
    assign w_mx_valid = w_sel ? m1_valid : m0_valid;
    assign w_done     = s_valid && s_ready;

    // On completion the current owner counts as "last", so a waiting peer takes over.
    assign w_pick_last = w_in_gnt ? w_sel : r_last_grant;

    rr_pick2 u_pick (
        .i_req  ({m1_valid, m0_valid}),
        .i_last (w_pick_last),
        .o_pick (w_pick)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_pick[0])      w_state_nxt = GNT0;
                else if (w_pick[1]) w_state_nxt = GNT1;
            end
            GNT0, GNT1: begin
                if (w_tmo)            w_state_nxt = IDLE;
                else if (w_done)      w_state_nxt = w_pick[1] ? GNT1 : GNT0;
                else if (!w_mx_valid) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_addr   = '0;
        s_wdata  = '0;
        s_wmask  = '0;
        s_wen    = 1'b0;
        s_valid  = 1'b0;
        grant_id = GRANT_NONE;
        w_ready  = 1'b0;
        w_rdata  = '0;
        m0_ready = 1'b0;
        m0_rdata = '0;
        m1_ready = 1'b0;
        m1_rdata = '0;
        if (w_in_gnt) begin
            s_valid  = w_mx_valid && !w_tmo;
            s_addr   = w_sel ? m1_addr  : m0_addr;
            s_wdata  = w_sel ? m1_wdata : m0_wdata;
            s_wmask  = w_sel ? m1_wmask : m0_wmask;
            s_wen    = (w_sel ? m1_wen : m0_wen) && w_mx_valid && !w_tmo;
            grant_id = w_sel ? GRANT_M1 : GRANT_M0;
            w_ready  = (s_ready && w_mx_valid) || w_tmo;
            w_rdata  = w_tmo ? BUS_ERR_WORD : s_rdata;
            if (w_sel) begin
                m1_ready = w_ready;
                m1_rdata = w_rdata;
            end else begin
                m0_ready = w_ready;
                m0_rdata = w_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            r_state <= w_state_nxt;
            if (w_done || w_tmo) r_last_grant <= w_sel;
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_done || w_tmo || (w_state_nxt != r_state)) begin
            r_cnt <= '0;
        end else if (w_in_gnt && s_valid && !s_ready) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_tmo = w_in_gnt && w_mx_valid && (r_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
    logic w_unused_cfg;

    assign w_tmo        = 1'b0;
    assign w_unused_cfg = ^TIMEOUT_CYCLES;
`endif

    assign bus_err = w_tmo;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter; inputs change 1 ns after the rising
// edge and outputs are sampled on the falling edge.
module tb_bus_arbiter;
    import bus_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wmask;
    logic        m0_valid, m0_wen, m0_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wmask;
    logic        m1_valid, m1_wen, m1_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wmask;
    logic        s_wen, s_valid, s_ready;
    logic [1:0]  grant_id;
    logic        bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk      (clk),      .rst_n    (rst_n),
        .m0_addr  (m0_addr),  .m0_valid (m0_valid), .m0_wdata (m0_wdata),
        .m0_wmask (m0_wmask), .m0_wen   (m0_wen),   .m0_rdata (m0_rdata),
        .m0_ready (m0_ready),
        .m1_addr  (m1_addr),  .m1_valid (m1_valid), .m1_wdata (m1_wdata),
        .m1_wmask (m1_wmask), .m1_wen   (m1_wen),   .m1_rdata (m1_rdata),
        .m1_ready (m1_ready),
        .s_addr   (s_addr),   .s_wdata  (s_wdata),  .s_wmask  (s_wmask),
        .s_wen    (s_wen),    .s_valid  (s_valid),  .s_rdata  (s_rdata),
        .s_ready  (s_ready),
        .grant_id (grant_id), .bus_err  (bus_err)
    );

    task automatic clear_inputs();
        m0_addr = '0; m0_valid = 1'b0; m0_wdata = '0; m0_wmask = '0; m0_wen = 1'b0;
        m1_addr = '0; m1_valid = 1'b0; m1_wdata = '0; m1_wmask = '0; m1_wen = 1'b0;
        s_rdata = '0; s_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic settle();
        tick();
        clear_inputs();
        repeat (2) tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n    = 1'b0;
        m0_valid = 1'b1;
        m1_valid = 1'b1;
        s_ready  = 1'b1;
        @(negedge clk);
        n_checks++; if (grant_id !== GRANT_NONE) begin n_fail++; $display("FAIL reset_grant: got %b expected %b", grant_id, GRANT_NONE); end
        n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL reset_s_valid: got %b expected 0", s_valid); end
        n_checks++; if ({m0_ready, m1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", {m0_ready, m1_ready}); end
        n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_bus_err: got %b expected 0", bus_err); end
        clear_inputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        m0_valid = 1'b1;
        m0_addr  = 32'h1000_0004;
        m0_wen   = 1'b0;
        s_rdata  = 32'h1234_5678;
        s_ready  = 1'b1;
        @(negedge clk);
        n_checks++; if ({s_valid, m0_ready, grant_id} !== 4'b0000) begin n_fail++; $display("FAIL single_arb_cycle: got %b expected 0000", {s_valid, m0_ready, grant_id}); end
        tick();
        @(negedge clk);
        n_checks++; if (s_valid !== 1'b1) begin n_fail++; $display("FAIL single_s_valid: got %b expected 1", s_valid); end
        n_checks++; if (s_addr !== 32'h1000_0004) begin n_fail++; $display("FAIL single_s_addr: got %h expected 10000004", s_addr); end
        n_checks++; if (s_wen !== 1'b0) begin n_fail++; $display("FAIL single_s_wen: got %b expected 0", s_wen); end
        n_checks++; if (m0_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b expected 1", m0_ready); end
        n_checks++; if (m0_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL single_rdata: got %h expected 12345678", m0_rdata); end
        n_checks++; if (grant_id !== GRANT_M0) begin n_fail++; $display("FAIL single_grant: got %b expected 01", grant_id); end
        n_checks++; if ({m1_ready, m1_rdata} !== 33'd0) begin n_fail++; $display("FAIL single_m1_quiet: got %b/%h expected 0/0", m1_ready, m1_rdata); end
        settle();
        @(negedge clk);
        n_checks++; if (grant_id !== GRANT_NONE) begin n_fail++; $display("FAIL single_back_idle: got %b expected 00", grant_id); end
    endtask

    task automatic test_tie();
        logic [1:0] exp_gnt;
        apply_reset();
        m0_valid = 1'b1; m0_addr = 32'h0000_0A00;
        m1_valid = 1'b1; m1_addr = 32'h0000_0B00;
        s_rdata  = 32'hCAFE_0000;
        s_ready  = 1'b1;
        @(negedge clk);
        n_checks++; if (grant_id !== GRANT_NONE) begin n_fail++; $display("FAIL tie_arb_cycle: got %b expected 00", grant_id); end
        for (int i = 1; i <= 4; i++) begin
            exp_gnt = (i % 2 == 1) ? GRANT_M0 : GRANT_M1;
            tick();
            @(negedge clk);
            n_checks++; if (grant_id !== exp_gnt) begin n_fail++; $display("FAIL tie_grant[%0d]: got %b expected %b", i, grant_id, exp_gnt); end
            n_checks++; if ({m1_ready, m0_ready} !== exp_gnt) begin n_fail++; $display("FAIL tie_ready[%0d]: got %b expected %b", i, {m1_ready, m0_ready}, exp_gnt); end
            n_checks++; if (s_addr !== ((i % 2 == 1) ? 32'h0000_0A00 : 32'h0000_0B00)) begin n_fail++; $display("FAIL tie_s_addr[%0d]: got %h", i, s_addr); end
        end
        settle();
    endtask

    task automatic test_uart_stall();
        m1_valid = 1'b1;
        m1_addr  = 32'h3000_0000;
        m1_wdata = 32'h0000_0055;
        m1_wmask = 4'b0001;
        m1_wen   = 1'b1;
        s_ready  = 1'b0;
        @(negedge clk);
        n_checks++; if (grant_id !== GRANT_NONE) begin n_fail++; $display("FAIL stall_arb_cycle: got %b expected 00", grant_id); end
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 3) begin
                m0_valid = 1'b1;
                m0_addr  = 32'h1000_0100;
            end
            @(negedge clk);
            n_checks++; if ({grant_id, s_valid, s_wen} !== 4'b1011) begin n_fail++; $display("FAIL stall_hold[%0d]: got gnt/valid/wen %b expected 1011", i, {grant_id, s_valid, s_wen}); end
            n_checks++; if ({s_addr, s_wdata, s_wmask} !== {32'h3000_0000, 32'h0000_0055, 4'b0001}) begin n_fail++; $display("FAIL stall_bus[%0d]: got %h %h %b", i, s_addr, s_wdata, s_wmask); end
            n_checks++; if ({m1_ready, m0_ready, bus_err} !== 3'b000) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b expected 000", i, {m1_ready, m0_ready, bus_err}); end
        end
        tick();
        s_ready = 1'b1;
        @(negedge clk);
        n_checks++; if ({m1_ready, m0_ready, grant_id} !== 4'b1010) begin n_fail++; $display("FAIL stall_release: got %b expected 1010", {m1_ready, m0_ready, grant_id}); end
        tick();
        m1_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({grant_id, m0_ready, s_wen} !== 4'b0110) begin n_fail++; $display("FAIL stall_m0_next: got %b expected 0110", {grant_id, m0_ready, s_wen}); end
        settle();
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses   = 0;
        m0_valid = 1'b1;
        m0_addr  = 32'h2000_0000;
        s_rdata  = 32'hA000_0000;
        s_ready  = 1'b1;
        @(negedge clk);
        n_checks++; if (m0_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_arb_cycle: got %b expected 0", m0_ready); end
        for (int i = 0; i < 4; i++) begin
            tick();
            m0_addr = 32'h2000_0000 + 32'(4 * i);
            s_rdata = 32'hA000_0000 + 32'(i);
            @(negedge clk);
            if (m0_ready === 1'b1) pulses++;
            n_checks++; if (s_addr !== 32'h2000_0000 + 32'(4 * i)) begin n_fail++; $display("FAIL b2b_s_addr[%0d]: got %h", i, s_addr); end
            n_checks++; if (m0_rdata !== 32'hA000_0000 + 32'(i)) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %h", i, m0_rdata); end
        end
        n_checks++; if (pulses !== 4) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 4", pulses); end
        tick();
        m0_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({m0_ready, s_valid} !== 2'b00) begin n_fail++; $display("FAIL b2b_after: got %b expected 00", {m0_ready, s_valid}); end
        settle();
    endtask

    task automatic test_reset_mid();
        m1_valid = 1'b1;
        m1_addr  = 32'h3000_0000;
        m1_wen   = 1'b1;
        s_ready  = 1'b0;
        tick();
        @(negedge clk);
        n_checks++; if ({grant_id, s_valid} !== 3'b101) begin n_fail++; $display("FAIL rstmid_pre: got %b expected 101", {grant_id, s_valid}); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({grant_id, s_valid, s_wen} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_async: got %b expected 0000", {grant_id, s_valid, s_wen}); end
        m1_wen   = 1'b0;
        m0_valid = 1'b1;
        s_ready  = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (grant_id !== GRANT_NONE) begin n_fail++; $display("FAIL rstmid_arb: got %b expected 00", grant_id); end
        tick();
        @(negedge clk);
        n_checks++; if ({grant_id, m0_ready} !== 3'b011) begin n_fail++; $display("FAIL rstmid_tie_m0: got %b expected 011", {grant_id, m0_ready}); end
        settle();
    endtask

`ifdef BUS_TIMEOUT_EN
    task automatic test_timeout();
        m0_valid = 1'b1;
        m0_addr  = 32'h1000_0000;
        s_rdata  = 32'h1111_1111;
        s_ready  = 1'b0;
        @(negedge clk);
        for (int i = 1; i <= 8; i++) begin
            tick();
            @(negedge clk);
            n_checks++; if ({m0_ready, bus_err, s_valid} !== 3'b001) begin n_fail++; $display("FAIL tmo_stall[%0d]: got %b expected 001", i, {m0_ready, bus_err, s_valid}); end
        end
        tick();
        @(negedge clk);
        n_checks++; if ({m0_ready, bus_err, s_valid} !== 3'b110) begin n_fail++; $display("FAIL tmo_fire: got %b expected 110", {m0_ready, bus_err, s_valid}); end
        n_checks++; if (m0_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL tmo_rdata: got %h expected deadbeef", m0_rdata); end
        tick();
        m0_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({grant_id, bus_err} !== 3'b000) begin n_fail++; $display("FAIL tmo_idle: got %b expected 000", {grant_id, bus_err}); end
        settle();
    endtask
`else
    task automatic test_timeout();
        m0_valid = 1'b1;
        s_rdata  = 32'h2222_2222;
        s_ready  = 1'b0;
        @(negedge clk);
        for (int i = 1; i <= 20; i++) begin
            tick();
            @(negedge clk);
            n_checks++; if ({grant_id, m0_ready, bus_err, s_valid} !== 5'b01001) begin n_fail++; $display("FAIL notmo_hold[%0d]: got %b expected 01001", i, {grant_id, m0_ready, bus_err, s_valid}); end
        end
        tick();
        s_ready = 1'b1;
        @(negedge clk);
        n_checks++; if ({m0_ready, m0_rdata} !== {1'b1, 32'h2222_2222}) begin n_fail++; $display("FAIL notmo_done: got %b/%h expected 1/22222222", m0_ready, m0_rdata); end
        settle();
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: got time limit expected normal end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_read();
        test_tie();
        test_uart_stall();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
